dram_arbiter: RTL and testbench

//  Shares the single 64KB DRAM port between the CPU data path and a secondary bus master (loader/DMA).

---
 rtl/cpu_pkg.sv | 15 +
 rtl/arb_starve_cnt.sv | 38 +++
 rtl/dram_arbiter.sv | 104 ++++++++++
 tb/tb_dram_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory map constants and the DRAM arbiter state type.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACK
  } arb_state_t;

  localparam logic [31:0] DRAM_BASE    = 32'h0000_4000;
  localparam logic [31:0] IO_BASE      = 32'hFFFF_F000;
  localparam int          DRAM_ADDR_W  = 14;
  localparam int          ARB_MAX_WAIT = 8;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter: counts cycles a DMA request is blocked by the CPU.
module arb_starve_cnt
  import cpu_pkg::*;
#(
  parameter int MAX = ARB_MAX_WAIT,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sat_o = (cnt_q == W'(MAX));

  // Clear wins over increment so the grant cycle always restarts the count from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single DRAM port between the CPU data path and a DMA master.
// CPU has priority; a starved DMA request steals one cycle and stalls the CPU.
module dram_arbiter #(
  parameter logic [31:0] DRAM_BASE = cpu_pkg::DRAM_BASE,
  parameter int          ADDR_W    = cpu_pkg::DRAM_ADDR_W,
  parameter int          MAX_WAIT  = cpu_pkg::ARB_MAX_WAIT
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cpu_mem,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_we,
  output logic [31:0]       ram_d,
  input  logic [31:0]       ram_spo
);

  localparam logic [31:0] WIN_SIZE = 32'd1 << (ADDR_W + 2);
  localparam logic [19:0] IO_PAGE  = cpu_pkg::IO_BASE[31:12];

  cpu_pkg::arb_state_t state_q;
  logic                dma_ack_q;
  logic [31:0]         dma_rdata_q;

  logic [31:0] cpu_off;
  logic [31:0] dma_off;
  logic        cpu_win;
  logic        dma_win;
  logic        dma_own;
  logic        starve_sat;
  logic        go_grant;

  assign cpu_off = cpu_addr - DRAM_BASE;
  assign dma_off = dma_addr - DRAM_BASE;

  // The MMIO page is excluded explicitly so a relocated window can never alias it.
  assign cpu_win = (cpu_addr >= DRAM_BASE) && (cpu_off < WIN_SIZE) && (cpu_addr[31:12] != IO_PAGE);
  assign dma_win = (dma_addr >= DRAM_BASE) && (dma_off < WIN_SIZE) && (dma_addr[31:12] != IO_PAGE);

  assign dma_own  = (state_q == cpu_pkg::GRANT);
  assign go_grant = (state_q == cpu_pkg::IDLE) && dma_req && (!cpu_mem || starve_sat);

  arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_starve (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i ((state_q == cpu_pkg::IDLE) && dma_req && cpu_mem),
    .clr_i (go_grant),
    .sat_o (starve_sat)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= cpu_pkg::IDLE;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      case (state_q)
        cpu_pkg::IDLE: begin
          if (go_grant) begin
            state_q <= cpu_pkg::GRANT;
          end
        end
        cpu_pkg::GRANT: begin
          state_q     <= cpu_pkg::ACK;
          dma_ack_q   <= 1'b1;
          dma_rdata_q <= dma_win ? ram_spo : '0;
        end
        cpu_pkg::ACK: begin
          state_q   <= cpu_pkg::IDLE;
          dma_ack_q <= 1'b0;
        end
        default: begin
          state_q   <= cpu_pkg::IDLE;
          dma_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Port mux is combinational because the DRAM read path is asynchronous.
  always_comb begin
    ram_a     = dma_own ? dma_off[ADDR_W+1:2] : cpu_off[ADDR_W+1:2];
    ram_d     = dma_own ? dma_wdata : cpu_wdata;
    ram_we    = rst_n && (dma_own ? (dma_we && dma_win) : (cpu_mem && cpu_we && cpu_win));
    cpu_stall = dma_own && cpu_mem;
    cpu_rdata = (!dma_own && cpu_win) ? ram_spo : '0;
  end

  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a cycle-slot reference model.
module tb_dram_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        cpu_mem;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic [13:0] ram_a;
  logic        ram_we;
  logic [31:0] ram_d;
  logic [31:0] ram_spo;

  always #5 clk_i = ~clk_i;

  dram_arbiter #(
    .DRAM_BASE (32'h0000_4000),
    .ADDR_W    (14),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .cpu_mem   (cpu_mem),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .ram_a     (ram_a),
    .ram_we    (ram_we),
    .ram_d     (ram_d),
    .ram_spo   (ram_spo)
  );

  // DRAM: asynchronous read, write on the clock edge
  logic [31:0] mem [0:16383];
  logic        mem_clr;
  assign ram_spo = mem[ram_a];
  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_a] <= ram_d;
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [0:16383];

  typedef struct packed {
    logic        mem_v;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic        chk_a;
    logic [13:0] exp_a;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit win(input logic [31:0] a);
    return (a >= 32'h4000) && ((a - 32'h4000) < 32'h0001_0000);
  endfunction

  function automatic logic [13:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'h4000) >> 2;
    return o[13:0];
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 6)       return 32'h4000 + ($urandom_range(0, 31) << 2);
    else if (k == 6) return 32'h13F80 + ($urandom_range(0, 31) << 2);
    else if (k == 7) return 32'h3FF0 + ($urandom_range(0, 3) << 2);
    else if (k == 8) return 32'hFFFF_F000 + ($urandom_range(0, 255) << 2);
    else             return 32'h14000 + ($urandom_range(0, 15) << 2);
  endfunction

  // Single DMA access with an idle CPU: grant next cycle, ack the cycle after.
  task automatic dma_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic exp_we, input logic [31:0] exp_rd);
    dma_addr = a; dma_we = w; dma_wdata = d; dma_req = 1'b1;
    #1;
    chk("xfer_req_no_ack", 32'(dma_ack), 32'd0);
    tick();
    chk("xfer_grant_we", 32'(ram_we), 32'(exp_we));
    chk("xfer_grant_a", 32'(ram_a), 32'(widx(a)));
    if (exp_we) chk("xfer_grant_d", ram_d, d);
    tick();
    chk("xfer_ack", 32'(dma_ack), 32'd1);
    chk("xfer_rdata", dma_rdata, exp_rd);
    $display("dma xfer addr=%h we=%0d rdata=%h", a, w, dma_rdata);
    dma_req = 1'b0;
    tick();
    chk("xfer_ack_drop", 32'(dma_ack), 32'd0);
  endtask

  // CPU busy every cycle with a DMA read pending: the grant is forced once the
  // wait count saturates, costing the CPU exactly one stalled cycle.
  task automatic starve_run(input string nm);
    int idx;
    idx = -1;
    cpu_mem = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4020;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (cpu_stall) begin
        idx = i;
        break;
      end
      tick();
    end
    chk({nm, "_grant_cycle"}, 32'(idx), 32'(MAX_WAIT + 1));
    chk({nm, "_grant_cpu_rdata"}, cpu_rdata, 32'd0);
    tick();
    chk({nm, "_ack_stall"}, 32'(cpu_stall), 32'd0);
    chk({nm, "_ack"}, 32'(dma_ack), 32'd1);
    chk({nm, "_rdata"}, dma_rdata, 32'hCAFE_F00D);
    $display("starve run %s granted after %0d cycles", nm, idx);
    dma_req = 1'b0;
    tick();
    chk({nm, "_after_stall"}, 32'(cpu_stall), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          last_grant;
    int          blocked;
    logic [31:0] cap_rd;
    bit          acked_last;
    bit          req_on;
    bit          slot;
    bit          ack_exp;
    logic [13:0] ea;
    logic        ewe;
    logic [31:0] ed;
    logic [31:0] erd;
    logic [31:0] ackv;

    // Reset state, with an in-window CPU store presented during reset
    rst_n = 1'b0; mem_clr = 1'b1;
    cpu_mem = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4010; cpu_wdata = 32'h0BAD_0BAD;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    tick();
    tick();
    mem_clr = 1'b0;
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    chk("reset_ack", 32'(dma_ack), 32'd0);
    chk("reset_dma_rdata", dma_rdata, 32'd0);
    cpu_mem = 1'b0; cpu_we = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // CPU-only vectors
    vecs[0] = '{1'b1, 1'b1, 32'h0000_4010, 32'hDEAD_BEEF, 1'b1, 1'b1, 14'h0004, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0001_3FFC, 32'h1234_5678, 1'b1, 1'b1, 14'h3FFF, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_F000, 32'hAAAA_5555, 1'b0, 1'b1, 14'h2C00, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_3FFC, 32'h1111_1111, 1'b0, 1'b1, 14'h3FFF, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0001_4000, 32'h2222_2222, 1'b0, 1'b1, 14'h0000, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_4020, 32'h3333_3333, 1'b0, 1'b1, 14'h0008, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_4010, 32'h0,         1'b0, 1'b1, 14'h0004, 1'b1, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 1'b0, 32'h0001_3FFC, 32'h0,         1'b0, 1'b1, 14'h3FFF, 1'b1, 32'h1234_5678};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         1'b0, 1'b1, 14'h0000, 1'b1, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 32'h0001_3FFC, 32'h0,         1'b0, 1'b1, 14'h3FFF, 1'b1, 32'h1234_5678};
    for (int v = 0; v < 10; v++) begin
      cpu_mem = vecs[v].mem_v; cpu_we = vecs[v].we;
      cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      #1;
      chk($sformatf("vec%0d_ram_we", v), 32'(ram_we), 32'(vecs[v].exp_we));
      chk($sformatf("vec%0d_stall", v), 32'(cpu_stall), 32'd0);
      if (vecs[v].chk_a) chk($sformatf("vec%0d_ram_a", v), 32'(ram_a), 32'(vecs[v].exp_a));
      if (vecs[v].exp_we) chk($sformatf("vec%0d_ram_d", v), ram_d, vecs[v].wdata);
      if (vecs[v].chk_rd) chk($sformatf("vec%0d_rdata", v), cpu_rdata, vecs[v].exp_rd);
      $display("vec %0d mem=%0d we=%0d addr=%h ram_we=%0d ram_a=%h rdata=%h",
               v, cpu_mem, cpu_we, cpu_addr, ram_we, ram_a, cpu_rdata);
      tick();
    end
    cpu_mem = 1'b0; cpu_we = 1'b0;

    // DMA accesses with an idle CPU, including out-of-window targets
    dma_xfer(32'h0000_4010, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
    dma_xfer(32'h0000_4020, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0);
    dma_xfer(32'h0000_4020, 1'b0, 32'h0, 1'b0, 32'hCAFE_F00D);
    dma_xfer(32'hFFFF_F060, 1'b1, 32'h7777_7777, 1'b0, 32'h0);
    dma_xfer(32'h0000_3FFC, 1'b1, 32'h8888_8888, 1'b0, 32'h0);
    dma_xfer(32'h0001_3FFC, 1'b0, 32'h0, 1'b0, 32'h1234_5678);

    // Starvation forcing
    starve_run("starve1");
    starve_run("starve2");

    // Reset in the middle of a grant
    cpu_mem = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h4010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4020;
    tick();
    chk("rst_pre_owner_a", 32'(ram_a), 32'h8);
    #2 rst_n = 1'b0; cpu_mem = 1'b1; cpu_we = 1'b1; cpu_wdata = 32'h5555_0000;
    #1;
    chk("rst_async_owner_a", 32'(ram_a), 32'h4);
    chk("rst_async_ram_we", 32'(ram_we), 32'd0);
    chk("rst_async_stall", 32'(cpu_stall), 32'd0);
    tick();
    chk("rst_no_ack1", 32'(dma_ack), 32'd0);
    chk("rst_rdata_clr", dma_rdata, 32'd0);
    tick();
    chk("rst_no_ack2", 32'(dma_ack), 32'd0);
    cpu_mem = 1'b0; cpu_we = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    chk("rst_regrant_a", 32'(ram_a), 32'h8);
    chk("rst_regrant_no_ack", 32'(dma_ack), 32'd0);
    tick();
    chk("rst_regrant_ack", 32'(dma_ack), 32'd1);
    chk("rst_regrant_rdata", dma_rdata, 32'hCAFE_F00D);
    dma_req = 1'b0;
    tick();

    // Partial wait count must be discarded by reset
    cpu_mem = 1'b1; dma_req = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0; dma_req = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    starve_run("post_rst");

    // Request held across three accesses: acks exactly three cycles apart
    cpu_mem = 1'b0; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4010;
    ackv = '0;
    for (int i = 0; i < 9; i++) begin
      #1;
      ackv[i] = dma_ack;
      if (i == 8) dma_req = 1'b0;
      tick();
    end
    chk("held_req_ack_pattern", ackv, 32'h124);
    $display("held request ack pattern=%b", ackv[8:0]);
    tick();
    tick();

    // Randomized run against the slot model
    rst_n = 1'b0; mem_clr = 1'b1; dma_req = 1'b0; cpu_mem = 1'b0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
    tick();
    mem_clr = 1'b0; rst_n = 1'b1;
    last_grant = -100; blocked = 0; cap_rd = '0; acked_last = 1'b0; req_on = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (acked_last || !req_on) begin
        if ($urandom_range(0, acked_last ? 2 : 3) == 0) begin
          req_on = 1'b1;
          dma_addr = rand_addr();
          dma_we = 1'($urandom_range(0, 1));
          dma_wdata = $urandom();
        end else begin
          req_on = 1'b0;
        end
      end
      dma_req = req_on;
      cpu_mem = ($urandom_range(0, 3) != 0);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = rand_addr();
      cpu_wdata = $urandom();
      #1;
      slot = (cyc == last_grant);
      ack_exp = (cyc == last_grant + 1);
      if (slot) begin
        ea = widx(dma_addr); ewe = dma_we && win(dma_addr); ed = dma_wdata; erd = '0;
        cap_rd = win(dma_addr) ? ref_mem[ea] : 32'h0;
      end else begin
        ea = widx(cpu_addr); ewe = cpu_mem && cpu_we && win(cpu_addr); ed = cpu_wdata;
        erd = win(cpu_addr) ? ref_mem[ea] : 32'h0;
      end
      chk("rnd_ram_a", 32'(ram_a), 32'(ea));
      chk("rnd_ram_we", 32'(ram_we), 32'(ewe));
      if (ewe) chk("rnd_ram_d", ram_d, ed);
      chk("rnd_stall", 32'(cpu_stall), 32'(slot && cpu_mem));
      chk("rnd_cpu_rdata", cpu_rdata, erd);
      chk("rnd_ack", 32'(dma_ack), 32'(ack_exp));
      if (ack_exp) begin
        chk("rnd_dma_rdata", dma_rdata, cap_rd);
        $display("rnd dma txn cyc=%0d addr=%h we=%0d rdata=%h", cyc, dma_addr, dma_we, dma_rdata);
      end
      if (ewe) ref_mem[ea] = ed;
      acked_last = ack_exp;
      if (cyc >= last_grant + 2 && dma_req) begin
        if (!cpu_mem || blocked == MAX_WAIT) begin
          last_grant = cyc + 1;
          blocked = 0;
        end else if (blocked < MAX_WAIT) begin
          blocked++;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
